// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline-stage register for the CPU datapath (IF/ID, ID/EX, ...).
//   Holds up to two payload entries: the main register, which drives the
//   output, and a skid register that absorbs one extra beat while the
//   downstream side is blocked. This keeps full throughput without a
//   combinational path from out_ready to in_ready.
//   A global stall freezes the stage. A flush empties it and drives the
//   bubble encoding on the output. Two saturating counters record stall and
//   flush events for performance analysis.
//
// Parameters
//   DATA_W       payload width in bits
//   FLUSH_VALUE  value driven on out_data_o after reset/flush (bubble/NOP)
//   CNT_W        width of the saturating event counters
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-low
//   flush_i      in   discard all held entries (highest priority)
//   stall_i      in   freeze stage: no accept, no issue, contents held
//   in_valid_i   in   upstream payload valid
//   in_ready_o   out  stage can accept this cycle
//   in_data_i    in   upstream payload
//   out_valid_o  out  out_data_o holds a valid entry
//   out_ready_i  in   downstream accepts this cycle
//   out_data_o   out  head entry (main register)
//   stall_cnt_o  out  cycles stalled while holding a valid entry (saturating)
//   flush_cnt_o  out  flushes that discarded at least one entry (saturating)
module pipe_stage_elastic #(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] FLUSH_VALUE = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_q, main_next;
  logic [DATA_W-1:0] skid_q, skid_next;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              acc, deq;
  logic              stall_event, flush_event;

  // Ready depends only on registered state plus stall/flush, never on
  // out_ready_i. rst_i gating keeps it low while reset is asserted.
  assign in_ready_o  = rst_i & (state != FULL) & ~stall_i & ~flush_i;
  assign out_valid_o = (state != EMPTY);
  assign out_data_o  = main_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  assign acc = in_valid_i & in_ready_o;
  assign deq = out_valid_o & out_ready_i & ~stall_i & ~flush_i;

  assign stall_event = stall_i & out_valid_o;
  assign flush_event = flush_i & (state != EMPTY);

  // Next-state logic. Stall needs no case of its own: it forces acc and
  // deq low, so every state falls through to "hold".
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    if (flush_i) begin
      state_next = EMPTY;
      main_next  = FLUSH_VALUE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_next = ONE;
            main_next  = in_data_i;
          end
        end
        ONE: begin
          if (acc && !deq) begin
            state_next = FULL;
            skid_next  = in_data_i;
          end else if (acc && deq) begin
            main_next = in_data_i;
          end else if (deq) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // The skid entry always follows main, preserving order.
          if (deq) begin
            state_next = ONE;
            main_next  = skid_q;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = FLUSH_VALUE;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= EMPTY;
      main_q <= FLUSH_VALUE;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  // Event counters stick at their maximum instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_event && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_event && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
